ahb_lite_mem_slave: RTL and testbench
=====================================

Name: ahb_lite_mem_slave

Overview:
Parametrised AHB-Lite slave memory model, the successor to the team's simple AHB slave memory. Adds the following over the earlier model:
- generic data width and depth
- separate wait-state counts per transfer type
- a write-protected address window
- alignment checking
- a proper two-cycle ERROR response
- HREADY (in) qualification for multi-slave systems

It sits behind the AHB-Lite decoder/mux in the verification fabric and serves as a backing store for master and bus-matrix tests.

Parameters:
AW, 32, address bus width
DW, 32, data bus width; 8/16/32/64 only
MS, 1024, memory size in bytes; power of two, >= DW/8
LW_NS, 0, wait states for NONSEQ write
LW_S, 0, wait states for SEQ write
LR_NS, 0, wait states for NONSEQ read
LR_S, 0, wait states for SEQ read
RO_BASE, 'h0, base byte address of the write-protected window (masked to memory)
RO_SIZE, 0, window size in bytes; 0 disables the window
INIT_PAT, 1, 1: byte k initialised to k[7:0] on reset; 0: memory untouched by reset

Ports:
hclk  in  1  bus clock
hresetn  in  1  asynchronous active-low reset
hsel  in  1  slave select
haddr  in  AW  address
htrans  in  2  IDLE/BUSY/NONSEQ/SEQ
hwrite  in  1  1 = write
hsize  in  3  transfer size; legal range is 0..log2(DW/8)
hburst  in  3  burst type; recorded only
hprot  in  4  protection; recorded only
hwdata  in  DW  write data, little-endian lanes
hready  in  1  bus HREADY (address phase qualifier)
hreadyout  out  1  slave ready
hresp  out  1  0 = OKAY, 1 = ERROR
hrdata  out  DW  read data

Behaviour:
Reset:
- hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, wait counter=0.
- If INIT_PAT=1, memory is loaded with the init pattern.
- Reset is asynchronous, applies mid-transfer, and abandons any pending write.

Address phase:
- Accepted when hsel & hready & htrans[1]; addr/write/size are registered.
- BUSY or IDLE while selected: zero-wait OKAY, no access.

Error checks on the accepted transfer:
- hsize > log2(DW/8): ERROR.
- haddr not aligned to 2^hsize: ERROR.
- Write whose masked address lies in [RO_BASE, RO_BASE+RO_SIZE): ERROR.
- Any error makes the data phase return ERROR; memory is unchanged.

FSM states and transitions:
- IDLE
  - On accept with error: ERR1.
  - On accept, no error, delay>0: WAIT, load counter=delay.
  - On accept, no error, delay=0: DATA.
- WAIT
  - hreadyout=0, hresp=0, counter decrements.
  - Counter=1: DATA.
- DATA
  - hreadyout=1, hresp=0.
  - Write: enabled lanes [addr%SW, addr%SW+2^hsize) are stored from hwdata at the clock edge ending the phase.
  - Read: hrdata carries those lanes; disabled lanes are driven 0.
  - Pipelined accept in the same cycle re-evaluates as in IDLE; otherwise go to IDLE.
- ERR1
  - hreadyout=0, hresp=1. Next state: ERR2.
- ERR2
  - hreadyout=1, hresp=1.
  - An accept in this cycle is honoured; otherwise go to IDLE.
  - A master that cancels with IDLE is simply served OKAY after.

Delay selection:
- htrans==SEQ uses LW_S/LR_S; NONSEQ uses LW_NS/LR_NS.
- Errors take no wait states before ERR1.

Addressing and data ordering:
- Address wraps modulo MS: index = haddr & (MS-1).
- A read immediately following a write to the same bytes returns the new data (write completes before the next data phase).
- hrdata holds its last value while hreadyout=0 and outside read data phases.
- hburst and hprot do not affect behaviour.

Decomposition:
- Package ahb_lite_pkg: htrans_t enum (IDLE, BUSY, NONSEQ, SEQ), hresp constants, hsize_t, the slave FSM state enum, and function lane_mask(addr, size, SW).
- One natural sub-module: ahb_lite_mem_slave_wait_ctrl (FSM, wait counter, hreadyout/hresp generation).
- Memory and lane logic stay in the top.

Test Plan:
- DW=32, zero waits: NONSEQ write 0xDEADBEEF to 0x10 with hsize=2, then read 0x10 -> hrdata=0xDEADBEEF, hreadyout never low, hresp=0.
- LR_NS=2, LR_S=1: INCR4 read from 0x20 after reset with INIT_PAT=1 -> beat 1 has 2 wait cycles, beats 2-4 have 1 each; data 0x23222120, 0x27262524, 0x2B2A2928, 0x2F2E2D2C.
- Byte write 0xAA to 0x13 with hsize=0, then word read 0x10 -> 0xAA121110.
- Misaligned word write to 0x02 -> data phase is ERR1 (hreadyout=0, hresp=1), then ERR2 (1,1); subsequent read of 0x00 returns 0x03020100.
- RO_BASE=0x100, RO_SIZE=0x40: write 0x104 -> ERROR, memory unchanged. Read 0x104 -> OKAY, returns 0x07060504. Write 0x140 -> OKAY.
- Assert hresetn low during a WAIT cycle of a write -> hreadyout=1 and hresp=0 immediately; the target address keeps its init value after reset release.

Source files
------------

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite types, response codes, slave FSM encodings and the byte-lane helper.
// Combinational definitions only; no latency or backpressure of its own.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef logic [2:0] hsize_t;

  typedef logic [2:0] slv_state_t;
  localparam slv_state_t ST_IDLE = 3'd0;
  localparam slv_state_t ST_WAIT = 3'd1;
  localparam slv_state_t ST_DATA = 3'd2;
  localparam slv_state_t ST_ERR1 = 3'd3;
  localparam slv_state_t ST_ERR2 = 3'd4;

  // Active byte lanes [addr%sw, addr%sw + 2^size); lanes at or above sw are never set.
  function automatic logic [7:0] lane_mask(input int addr, input int size, input int sw);
    logic [7:0] m;
    int         off;
    int         len;
    off = addr % sw;
    len = 1 << size;
    m   = '0;
    for (int i = 0; i < 8; i++) begin
      m[i] = (i < sw) && (i >= off) && (i < off + len);
    end
    return m;
  endfunction

endpackage

// File: rtl/ahb_lite_mem_slave_wait_ctrl.sv
// Data-phase sequencer: IDLE/WAIT/DATA/ERR1/ERR2 with a wait-state down-counter.
// Latency = programmed delay (errors: 2-cycle ERROR); holds hreadyout low through WAIT and ERR1.
module ahb_lite_mem_slave_wait_ctrl
  import ahb_lite_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic          accept,
  input  logic          acc_err,
  input  logic [CW-1:0] acc_delay,
  output slv_state_t    state,
  output logic          hreadyout,
  output logic          hresp
);

  slv_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_WAIT: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == CW'(1)) state_nxt = ST_DATA;
      end
      ST_ERR1: state_nxt = ST_ERR2;
      // IDLE, DATA and ERR2 all sit at a point where a new address phase may complete
      default: begin
        if (accept) begin
          if (acc_err) begin
            state_nxt = ST_ERR1;
          end else if (acc_delay != '0) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = acc_delay;
          end else begin
            state_nxt = ST_DATA;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign hreadyout = !((state == ST_WAIT) || (state == ST_ERR1));
  assign hresp     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite byte-addressed memory slave with per-type wait states, RO window and alignment errors.
// Data phase follows accept after 0..N waits; stalls the bus with hreadyout during WAIT and ERR1.
module ahb_lite_mem_slave
  import ahb_lite_pkg::*;
#(
  parameter int          AW       = 32,
  parameter int          DW       = 32,
  parameter int          MS       = 1024,
  parameter int          LW_NS    = 0,
  parameter int          LW_S     = 0,
  parameter int          LR_NS    = 0,
  parameter int          LR_S     = 0,
  parameter int unsigned RO_BASE  = 'h0,
  parameter int unsigned RO_SIZE  = 0,
  parameter int          INIT_PAT = 1
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic          hsel,
  input  logic [AW-1:0] haddr,
  input  logic [1:0]    htrans,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic [2:0]    hburst,
  input  logic [3:0]    hprot,
  input  logic [DW-1:0] hwdata,
  input  logic          hready,
  output logic          hreadyout,
  output logic          hresp,
  output logic [DW-1:0] hrdata
);

  localparam int          SW    = DW / 8;
  localparam int          SZW   = $clog2(SW);
  localparam int          AB    = $clog2(MS);
  localparam int          CW    = 8;
  localparam int unsigned RO_LO = RO_BASE & (MS - 1);
  localparam int unsigned RO_HI = RO_LO + RO_SIZE;

  slv_state_t    state;
  logic          accept;
  logic          acc_err;
  logic [CW-1:0] acc_delay;
  logic [AB-1:0] acc_idx;
  logic [7:0]    align_mask;
  logic          size_err;
  logic          misalign;
  logic          in_ro;

  logic [AB-1:0] base_q;
  logic          wr_q;
  logic [7:0]    mask_q;
  hsize_t        size_q;
  logic [2:0]    hburst_q;
  logic [3:0]    hprot_q;

  logic          wr_en;
  logic [DW-1:0] rd_word;
  logic [DW-1:0] hrdata_q;
  logic [7:0]    mem [MS];

  // hreadyout in the qualifier keeps ERR1/WAIT from taking a new address even if hready glitches high
  assign accept   = hsel && hready && htrans[1] && hreadyout;
  assign acc_idx  = haddr[AB-1:0];

  assign align_mask = (8'd1 << hsize) - 8'd1;
  assign size_err   = hsize > 3'(SZW);
  assign misalign   = |(haddr[7:0] & align_mask);
  assign in_ro      = (RO_SIZE != 0) && (32'(acc_idx) >= RO_LO) && (32'(acc_idx) < RO_HI);
  assign acc_err    = size_err || misalign || (hwrite && in_ro);

  always_comb begin
    if (htrans == HTRANS_SEQ) acc_delay = hwrite ? CW'(LW_S)  : CW'(LR_S);
    else                      acc_delay = hwrite ? CW'(LW_NS) : CW'(LR_NS);
  end

  ahb_lite_mem_slave_wait_ctrl #(
    .CW(CW)
  ) u_wait_ctrl (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .accept    (accept),
    .acc_err   (acc_err),
    .acc_delay (acc_delay),
    .state     (state),
    .hreadyout (hreadyout),
    .hresp     (hresp)
  );

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      base_q   <= '0;
      wr_q     <= 1'b0;
      mask_q   <= '0;
      size_q   <= '0;
      hburst_q <= '0;
      hprot_q  <= '0;
    end else if (accept) begin
      base_q   <= acc_idx & ~AB'(SW - 1);
      wr_q     <= hwrite;
      mask_q   <= lane_mask(int'(haddr[2:0]), int'(hsize), SW);
      size_q   <= hsize;
      hburst_q <= hburst;
      hprot_q  <= hprot;
    end
  end

  // DATA is only ever entered for error-free transfers, so no error gating is needed here
  assign wr_en = (state == ST_DATA) && wr_q;

  if (INIT_PAT != 0) begin : g_mem_init
    always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
        for (int k = 0; k < MS; k++) mem[k] <= 8'(k);
      end else if (wr_en) begin
        for (int i = 0; i < SW; i++) begin
          if (mask_q[i]) mem[base_q | AB'(i)] <= hwdata[8*i +: 8];
        end
      end
    end
  end else begin : g_mem_plain
    always_ff @(posedge hclk) begin
      if (wr_en) begin
        for (int i = 0; i < SW; i++) begin
          if (mask_q[i]) mem[base_q | AB'(i)] <= hwdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < SW; i++) begin
      if (mask_q[i]) rd_word[8*i +: 8] = mem[base_q | AB'(i)];
    end
  end

  // Read data is live only in a read DATA phase; everywhere else the last value is held
  assign hrdata = ((state == ST_DATA) && !wr_q) ? rd_word : hrdata_q;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) hrdata_q <= '0;
    else          hrdata_q <= hrdata;
  end

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Scoreboarded bench for ahb_lite_mem_slave: pipelined AHB-Lite driver, byte-array reference model.
`timescale 1ns/1ps
module tb_ahb_lite_mem_slave;
  import ahb_lite_pkg::*;

  localparam int          MS       = 1024;
  localparam int          LW_NS    = 1;
  localparam int          LW_S     = 0;
  localparam int          LR_NS    = 2;
  localparam int          LR_S     = 1;
  localparam int unsigned RO_BASE  = 'h100;
  localparam int unsigned RO_SIZE  = 'h40;

  logic        hclk    = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel    = 1'b0;
  logic [31:0] haddr   = '0;
  logic [1:0]  htrans  = 2'b00;
  logic        hwrite  = 1'b0;
  logic [2:0]  hsize   = '0;
  logic [2:0]  hburst  = '0;
  logic [3:0]  hprot   = '0;
  logic [31:0] hwdata  = '0;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  assign hready = hreadyout;
  always #5 hclk = ~hclk;

  ahb_lite_mem_slave #(
    .AW(32), .DW(32), .MS(MS),
    .LW_NS(LW_NS), .LW_S(LW_S), .LR_NS(LR_NS), .LR_S(LR_S),
    .RO_BASE(RO_BASE), .RO_SIZE(RO_SIZE), .INIT_PAT(1)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hready(hready), .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic [31:0] wdata;
  } xfer_t;

  typedef struct {
    logic [31:0] rdata;
    logic        resp;
    int          waits;
    logic        wr;
  } exp_t;

  xfer_t      stim[$];
  exp_t       sb[$];
  logic [7:0] model [MS];
  int         vectors     = 0;
  int         miscompares = 0;

  function automatic void model_init();
    for (int k = 0; k < MS; k++) model[k] = 8'(k);
  endfunction

  function automatic exp_t predict(xfer_t x);
    exp_t e;
    int   a, base, off, len;
    bit   err;
    a    = int'(x.addr) & (MS - 1);
    base = a & ~3;
    off  = a & 3;
    len  = 1 << x.size;
    err  = (x.size > 3'd2) || ((a % len) != 0) ||
           (x.wr && (a >= int'(RO_BASE)) && (a < int'(RO_BASE + RO_SIZE)));
    e.resp  = err;
    e.wr    = x.wr;
    e.rdata = '0;
    if (err)       e.waits = 1;
    else if (x.wr) e.waits = (x.trans == HTRANS_SEQ) ? LW_S : LW_NS;
    else           e.waits = (x.trans == HTRANS_SEQ) ? LR_S : LR_NS;
    if (!err) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + len) begin
          if (x.wr) model[base + i] = x.wdata[8*i +: 8];
          else      e.rdata[8*i +: 8] = model[base + i];
        end
      end
    end
    return e;
  endfunction

  task automatic add(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                     input logic [1:0] tr, input logic [31:0] wd);
    xfer_t x;
    x.addr = a; x.wr = wr; x.size = sz; x.trans = tr; x.wdata = wd;
    stim.push_back(x);
  endtask

  task automatic bus_idle();
    hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; haddr = '0; hsize = '0; hwdata = '0;
  endtask

  // Drives queued transfers with address/data overlap; expected values enter the scoreboard at accept.
  task automatic run_stim(input string name);
    xfer_t       ca, cd;
    exp_t        e;
    bit          a_v, d_v;
    int          waits, budget;
    logic        rdy, rsp;
    logic [31:0] rd;
    a_v = 0; d_v = 0; waits = 0; budget = 0;
    @(posedge hclk); #1;
    while ((stim.size() > 0 || a_v || d_v) && budget < 400) begin
      if (!a_v && stim.size() > 0) begin
        ca  = stim.pop_front();
        a_v = 1;
      end
      hsel   = a_v;
      htrans = a_v ? ca.trans : HTRANS_IDLE;
      haddr  = a_v ? ca.addr : 32'h0;
      hwrite = a_v && ca.wr;
      hsize  = a_v ? ca.size : 3'd0;
      hburst = 3'd1;
      hprot  = 4'h3;
      hwdata = (d_v && cd.wr) ? cd.wdata : 32'h0;
      @(negedge hclk);
      rdy = hreadyout; rsp = hresp; rd = hrdata;
      if (d_v) begin
        if (!rdy) begin
          e = sb[0];
          waits++;
          vectors++;
          if (rsp !== e.resp) begin
            miscompares++;
            $display("FAIL %s stall-cycle hresp @%h: got %0b want %0b", name, cd.addr, rsp, e.resp);
          end
        end else begin
          e = sb.pop_front();
          vectors++;
          if (rsp !== e.resp) begin
            miscompares++;
            $display("FAIL %s hresp @%h: got %0b want %0b", name, cd.addr, rsp, e.resp);
          end
          vectors++;
          if (waits != e.waits) begin
            miscompares++;
            $display("FAIL %s wait count @%h: got %0d want %0d", name, cd.addr, waits, e.waits);
          end
          if (!e.wr && !e.resp) begin
            vectors++;
            if (rd !== e.rdata) begin
              miscompares++;
              $display("FAIL %s hrdata @%h: got %h want %h", name, cd.addr, rd, e.rdata);
            end
          end
        end
      end
      @(posedge hclk); #1;
      budget++;
      if (rdy) begin
        d_v = 0;
        if (a_v) begin
          sb.push_back(predict(ca));
          cd    = ca;
          d_v   = 1;
          a_v   = 0;
          waits = 0;
        end
      end
    end
    if (budget >= 400) begin
      miscompares++;
      $display("FAIL %s timeout: %0d transfers left, %0d cycles", name, stim.size() + sb.size(), budget);
      stim.delete();
      sb.delete();
    end
    bus_idle();
  endtask

  task automatic test_reset();
    bus_idle();
    hresetn = 1'b0;
    model_init();
    stim.delete();
    sb.delete();
    repeat (2) @(posedge hclk);
    #1;
    vectors++;
    if (hreadyout !== 1'b1) begin miscompares++; $display("FAIL reset hreadyout: got %b want 1", hreadyout); end
    vectors++;
    if (hresp !== 1'b0) begin miscompares++; $display("FAIL reset hresp: got %b want 0", hresp); end
    vectors++;
    if (hrdata !== 32'h0) begin miscompares++; $display("FAIL reset hrdata: got %h want 0", hrdata); end
    @(negedge hclk);
    hresetn = 1'b1;
  endtask

  task automatic test_idle_busy();
    @(posedge hclk); #1;
    hsel = 1'b1; htrans = HTRANS_BUSY; haddr = 32'h104; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    htrans = HTRANS_IDLE; haddr = 32'h3; hsize = 3'd3;
    @(negedge hclk);
    vectors++;
    if (hreadyout !== 1'b1 || hresp !== 1'b0) begin
      miscompares++;
      $display("FAIL busy data phase: got ready=%b resp=%b want 1/0", hreadyout, hresp);
    end
    @(posedge hclk); #1;
    bus_idle();
    @(negedge hclk);
    vectors++;
    if (hreadyout !== 1'b1 || hresp !== 1'b0) begin
      miscompares++;
      $display("FAIL idle data phase: got ready=%b resp=%b want 1/0", hreadyout, hresp);
    end
  endtask

  task automatic test_write_read();
    add(32'h10, 1, 3'd2, HTRANS_NONSEQ, 32'hDEADBEEF);
    add(32'h10, 0, 3'd2, HTRANS_NONSEQ, 32'h0);
    add(32'h22, 1, 3'd1, HTRANS_NONSEQ, 32'h5A5A0000);
    add(32'h20, 0, 3'd2, HTRANS_NONSEQ, 32'h0);
    run_stim("write_read");
  endtask

  task automatic test_burst_read();
    test_reset();
    add(32'h20, 0, 3'd2, HTRANS_NONSEQ, 32'h0);
    add(32'h24, 0, 3'd2, HTRANS_SEQ,    32'h0);
    add(32'h28, 0, 3'd2, HTRANS_SEQ,    32'h0);
    add(32'h2C, 0, 3'd2, HTRANS_SEQ,    32'h0);
    run_stim("incr4_read");
  endtask

  task automatic test_byte_write();
    add(32'h13, 1, 3'd0, HTRANS_NONSEQ, 32'hAA000000);
    add(32'h10, 0, 3'd2, HTRANS_NONSEQ, 32'h0);
    add(32'h13, 0, 3'd0, HTRANS_NONSEQ, 32'h0);
    add(32'h12, 0, 3'd1, HTRANS_NONSEQ, 32'h0);
    run_stim("byte_write");
  endtask

  task automatic test_errors();
    add(32'h02, 1, 3'd2, HTRANS_NONSEQ, 32'h11223344);
    add(32'h00, 0, 3'd2, HTRANS_NONSEQ, 32'h0);
    add(32'h01, 0, 3'd1, HTRANS_NONSEQ, 32'h0);
    add(32'h08, 0, 3'd3, HTRANS_NONSEQ, 32'h0);
    add(32'h04, 0, 3'd2, HTRANS_SEQ,    32'h0);
    run_stim("errors");
  endtask

  task automatic test_ro_window();
    add(32'h104, 1, 3'd2, HTRANS_NONSEQ, 32'hCAFEF00D);
    add(32'h104, 0, 3'd2, HTRANS_NONSEQ, 32'h0);
    add(32'h140, 1, 3'd2, HTRANS_NONSEQ, 32'h55667788);
    add(32'h140, 0, 3'd2, HTRANS_NONSEQ, 32'h0);
    add(32'h13F, 1, 3'd0, HTRANS_NONSEQ, 32'h77000000);
    add(32'h13C, 0, 3'd2, HTRANS_NONSEQ, 32'h0);
    add(32'h0FF, 1, 3'd0, HTRANS_NONSEQ, 32'h99000000);
    add(32'h0FC, 0, 3'd2, HTRANS_NONSEQ, 32'h0);
    add(32'h504, 1, 3'd2, HTRANS_NONSEQ, 32'h01010101);
    run_stim("ro_window");
  endtask

  task automatic test_back_to_back();
    add(32'h40,  1, 3'd2, HTRANS_NONSEQ, 32'hA5A5_0001);
    add(32'h44,  1, 3'd2, HTRANS_SEQ,    32'hB6B6_0002);
    add(32'h44,  0, 3'd2, HTRANS_NONSEQ, 32'h0);
    add(32'h440, 0, 3'd2, HTRANS_NONSEQ, 32'h0);
    add(32'h48,  1, 3'd1, HTRANS_NONSEQ, 32'h0000BEEF);
    add(32'h48,  0, 3'd2, HTRANS_SEQ,    32'h0);
    add(32'h3FC, 1, 3'd2, HTRANS_NONSEQ, 32'hC0DEC0DE);
    add(32'h7FC, 0, 3'd2, HTRANS_NONSEQ, 32'h0);
    run_stim("back_to_back");
  endtask

  task automatic test_reset_mid();
    @(posedge hclk); #1;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; hwdata = 32'h12345678;
    @(negedge hclk);
    vectors++;
    if (hreadyout !== 1'b0) begin miscompares++; $display("FAIL rst_mid stall: got ready=%b want 0", hreadyout); end
    #1 hresetn = 1'b0;
    #1;
    vectors++;
    if (hreadyout !== 1'b1) begin miscompares++; $display("FAIL rst_mid hreadyout: got %b want 1", hreadyout); end
    vectors++;
    if (hresp !== 1'b0) begin miscompares++; $display("FAIL rst_mid hresp: got %b want 0", hresp); end
    model_init();
    stim.delete();
    sb.delete();
    bus_idle();
    @(negedge hclk);
    hresetn = 1'b1;
    add(32'h30, 0, 3'd2, HTRANS_NONSEQ, 32'h0);
    run_stim("rst_mid_readback");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (vectors=%0d miscompares=%0d)", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_busy();
    test_write_read();
    test_burst_read();
    test_byte_write();
    test_errors();
    test_ro_window();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
